// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: MIPS execute stage plus EX/MEM pipeline register.
//   Operand forwarding muxes, ALU control decode, ALU, branch-target adder and
//   RegDst mux. All state updates on the falling edge of clock; reset is
//   synchronous and active-high. Priority at each edge: reset > flush > stall > normal.
//   Optional iterative multiplier enabled by defining EX_MUL_EN. It computes
//   one shift-add step per cycle and raises busy while running. Without
//   EX_MUL_EN, busy is tied to 0 and funct 011000 decodes as an unknown op.
// Ports:
//   clock, reset                 stage clock (falling edge), sync reset
//   in_valid, stall, flush       ID/EX valid, downstream hold, kill
//   sign_ext                     immediate; [5:0] is the funct field
//   in_data1/2, fwd_a/b_sel      register operands and forwarding selects
//   mem_fwd_data, wb_fwd_data    forwarded results from MEM and WB
//   in_pc, rt, rd, alu_op, alu_src, reg_dst and the control bits come from ID/EX
//   busy                         multiply in progress (combinational)
//   out_*, alu_result, zero, out_data2, branch_pc, cur_pc, wr: EX/MEM register
module ex_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 10,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [1:0]        fwd_a_sel,
    input  logic [1:0]        fwd_b_sel,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [DATA_W-1:0] wb_fwd_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [1:0]        alu_op,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              branch,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] out_data2,
    output logic [PC_W-1:0]   branch_pc,
    output logic [PC_W-1:0]   cur_pc,
    output logic [REG_AW-1:0] wr,
    output logic              out_branch,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              out_reg_write
);

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnNor = 6'b100111;
    localparam logic [5:0] FnSlt = 6'b101010;

    logic [DATA_W-1:0] fwdA, fwdB, opB, aluRes;
    logic [5:0]        funct;
    logic [PC_W-1:0]   bpcNew;
    logic [REG_AW-1:0] wrNew;
    // Control bundle order: branch, mem_read, mem_write, mem_to_reg, reg_write
    logic [4:0]        ctlIn, ctlQ, ctlD;

    logic              validD, zeroD;
    logic [DATA_W-1:0] resD, data2D;
    logic [PC_W-1:0]   bpcD, pcD;
    logic [REG_AW-1:0] wrD;

    assign funct  = sign_ext[5:0];
    assign bpcNew = in_pc + sign_ext[PC_W-1:0];
    assign wrNew  = reg_dst ? rd : rt;
    assign ctlIn  = {branch, mem_read, mem_write, mem_to_reg, reg_write};
    assign {out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write} = ctlQ;

    // Forwarding muxes and ALU
    always_comb begin
        case (fwd_a_sel)
            2'b01:   fwdA = wb_fwd_data;
            2'b10:   fwdA = mem_fwd_data;
            default: fwdA = in_data1;
        endcase
        case (fwd_b_sel)
            2'b01:   fwdB = wb_fwd_data;
            2'b10:   fwdB = mem_fwd_data;
            default: fwdB = in_data2;
        endcase
        opB    = alu_src ? sign_ext : fwdB;
        aluRes = '0;
        case (alu_op)
            2'b00: aluRes = fwdA + opB;
            2'b01: aluRes = fwdA - opB;
            2'b11: aluRes = fwdA | opB;
            default: begin
                // Multiply funct lands in default here; its result comes from the FSM.
                case (funct)
                    FnAdd:   aluRes = fwdA + opB;
                    FnSub:   aluRes = fwdA - opB;
                    FnAnd:   aluRes = fwdA & opB;
                    FnOr:    aluRes = fwdA | opB;
                    FnNor:   aluRes = ~(fwdA | opB);
                    FnSlt:   aluRes = {{(DATA_W-1){1'b0}}, ($signed(fwdA) < $signed(opB))};
                    default: aluRes = '0;
                endcase
            end
        endcase
    end

`ifdef EX_MUL_EN
    localparam logic [5:0]  FnMult = 6'b011000;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} stateT;

    stateT             stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [DATA_W-1:0] mcandQ, mcandD, mplierQ, mplierD, prodQ, prodD, mData2Q, mData2D;
    logic [PC_W-1:0]   mPcQ, mPcD, mBpcQ, mBpcD;
    logic [REG_AW-1:0] mWrQ, mWrD;
    logic [4:0]        mCtlQ, mCtlD;
    logic              isMult;

    assign isMult = (alu_op == 2'b10) && (funct == FnMult);
    assign busy   = (stateQ != StIdle) || (in_valid && isMult && !flush);

    always_comb begin
        validD  = out_valid;
        ctlD    = ctlQ;
        resD    = alu_result;
        zeroD   = zero;
        data2D  = out_data2;
        bpcD    = branch_pc;
        pcD     = cur_pc;
        wrD     = wr;
        stateD  = stateQ;
        cntD    = cntQ;
        mcandD  = mcandQ;
        mplierD = mplierQ;
        prodD   = prodQ;
        mData2D = mData2Q;
        mPcD    = mPcQ;
        mBpcD   = mBpcQ;
        mWrD    = mWrQ;
        mCtlD   = mCtlQ;
        if (flush) begin
            validD = 1'b0;
            ctlD   = '0;
            stateD = StIdle;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (!stall) begin
                        if (in_valid && isMult) begin
                            // Launch: capture operands and EX/MEM fields, commit a bubble
                            mcandD  = fwdA;
                            mplierD = opB;
                            prodD   = '0;
                            cntD    = '0;
                            mData2D = fwdB;
                            mPcD    = in_pc;
                            mBpcD   = bpcNew;
                            mWrD    = wrNew;
                            mCtlD   = ctlIn;
                            validD  = 1'b0;
                            ctlD    = '0;
                            stateD  = StMul;
                        end else begin
                            validD = in_valid;
                            ctlD   = in_valid ? ctlIn : '0;
                            resD   = aluRes;
                            zeroD  = (aluRes == '0);
                            data2D = fwdB;
                            bpcD   = bpcNew;
                            pcD    = in_pc;
                            wrD    = wrNew;
                        end
                    end
                end
                StMul: begin
                    // Steps keep running under stall; only the commit waits.
                    if (mplierQ[0]) prodD = prodQ + mcandQ;
                    mcandD  = mcandQ << 1;
                    mplierD = mplierQ >> 1;
                    cntD    = cntQ + CNT_W'(1);
                    if (cntQ == CNT_W'(DATA_W - 1)) stateD = StDone;
                end
                StDone: begin
                    if (!stall) begin
                        validD = 1'b1;
                        ctlD   = mCtlQ;
                        resD   = prodQ;
                        zeroD  = (prodQ == '0);
                        data2D = mData2Q;
                        bpcD   = mBpcQ;
                        pcD    = mPcQ;
                        wrD    = mWrQ;
                        stateD = StIdle;
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            stateQ  <= StIdle;
            cntQ    <= '0;
            mcandQ  <= '0;
            mplierQ <= '0;
            prodQ   <= '0;
            mData2Q <= '0;
            mPcQ    <= '0;
            mBpcQ   <= '0;
            mWrQ    <= '0;
            mCtlQ   <= '0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            mcandQ  <= mcandD;
            mplierQ <= mplierD;
            prodQ   <= prodD;
            mData2Q <= mData2D;
            mPcQ    <= mPcD;
            mBpcQ   <= mBpcD;
            mWrQ    <= mWrD;
            mCtlQ   <= mCtlD;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        validD = out_valid;
        ctlD   = ctlQ;
        resD   = alu_result;
        zeroD  = zero;
        data2D = out_data2;
        bpcD   = branch_pc;
        pcD    = cur_pc;
        wrD    = wr;
        if (flush) begin
            validD = 1'b0;
            ctlD   = '0;
        end else if (!stall) begin
            validD = in_valid;
            ctlD   = in_valid ? ctlIn : '0;
            resD   = aluRes;
            zeroD  = (aluRes == '0);
            data2D = fwdB;
            bpcD   = bpcNew;
            pcD    = in_pc;
            wrD    = wrNew;
        end
    end
`endif

    // EX/MEM register
    always_ff @(negedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            ctlQ       <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
            out_data2  <= '0;
            branch_pc  <= '0;
            cur_pc     <= '0;
            wr         <= '0;
        end else begin
            out_valid  <= validD;
            ctlQ       <= ctlD;
            alu_result <= resD;
            zero       <= zeroD;
            out_data2  <= data2D;
            branch_pc  <= bpcD;
            cur_pc     <= pcD;
            wr         <= wrD;
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Testbench for ex_stage_pipe: directed steps followed by randomized traffic,
// checked against an arithmetic reference model of the EX/MEM register.
module tb_ex_stage_pipe;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 10;
    localparam int unsigned REG_AW = 5;

    logic              clock, reset, in_valid, stall, flush;
    logic [DATA_W-1:0] sign_ext, in_data1, in_data2, mem_fwd_data, wb_fwd_data;
    logic [1:0]        fwd_a_sel, fwd_b_sel, alu_op;
    logic [PC_W-1:0]   in_pc;
    logic [REG_AW-1:0] rt, rd;
    logic              alu_src, reg_dst, branch, mem_read, mem_write, mem_to_reg, reg_write;
    logic              busy, out_valid, zero;
    logic [DATA_W-1:0] alu_result, out_data2;
    logic [PC_W-1:0]   branch_pc, cur_pc;
    logic [REG_AW-1:0] wr;
    logic              out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;

    int checks   = 0;
    int failures = 0;

    // Reference model of the EX/MEM register contents
    logic              eValid, eZero;
    logic [4:0]        eCtl;
    logic [DATA_W-1:0] eRes, eData2;
    logic [PC_W-1:0]   eBpc, ePc;
    logic [REG_AW-1:0] eWr;

    logic [5:0] fnTable [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h18, 6'h3F};

    ex_stage_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .sign_ext(sign_ext), .in_data1(in_data1), .in_data2(in_data2),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .in_pc(in_pc), .rt(rt), .rd(rd), .alu_op(alu_op), .alu_src(alu_src),
        .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .busy(busy), .out_valid(out_valid),
        .alu_result(alu_result), .zero(zero), .out_data2(out_data2), .branch_pc(branch_pc),
        .cur_pc(cur_pc), .wr(wr), .out_branch(out_branch), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_reg_write(out_reg_write)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // State changes on the falling edge; sample 1 time unit later.
    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic setCtl(input logic [4:0] c);
        {branch, mem_read, mem_write, mem_to_reg, reg_write} = c;
    endtask

    function automatic logic [4:0] outCtl();
        return {out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write};
    endfunction

    function automatic logic [31:0] pickFwd(input logic [1:0] sel, input logic [31:0] regVal);
        if (sel == 2'b01) return wb_fwd_data;
        if (sel == 2'b10) return mem_fwd_data;
        return regVal;
    endfunction

    function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [5:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return a | b;
        if (f == 6'h20) return a + b;
        if (f == 6'h22) return a - b;
        if (f == 6'h24) return a & b;
        if (f == 6'h25) return a | b;
        if (f == 6'h27) return ~(a | b);
        if (f == 6'h2A) return (sa < sb) ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    task automatic clearModel;
        eValid = 1'b0; eZero = 1'b0; eCtl = '0; eRes = '0; eData2 = '0;
        eBpc = '0; ePc = '0; eWr = '0;
    endtask

    // Predict the register contents after the coming edge from the current inputs.
    task automatic modelEdge;
        logic [31:0] a, bReg, b;
        int sum;
        if (reset) begin
            clearModel();
        end else if (flush) begin
            eValid = 1'b0;
            eCtl   = '0;
        end else if (!stall) begin
            eValid = in_valid;
            eCtl   = in_valid ? {branch, mem_read, mem_write, mem_to_reg, reg_write} : 5'd0;
            if (in_valid) begin
                a      = pickFwd(fwd_a_sel, in_data1);
                bReg   = pickFwd(fwd_b_sel, in_data2);
                b      = alu_src ? sign_ext : bReg;
                eRes   = refAlu(alu_op, sign_ext[5:0], a, b);
                eZero  = (eRes == 0);
                eData2 = bReg;
                sum    = int'(in_pc) + int'(sign_ext[PC_W-1:0]);
                eBpc   = PC_W'(sum % (1 << PC_W));
                ePc    = in_pc;
                eWr    = reg_dst ? rd : rt;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, "_valid"}, out_valid, eValid);
        check({tag, "_ctl"}, outCtl(), eCtl);
        if (eValid) begin
            check({tag, "_res"}, alu_result, eRes);
            check({tag, "_zero"}, zero, eZero);
            check({tag, "_data2"}, out_data2, eData2);
            check({tag, "_bpc"}, branch_pc, eBpc);
            check({tag, "_pc"}, cur_pc, ePc);
            check({tag, "_wr"}, wr, eWr);
        end
    endtask

    initial begin
        logic [31:0] rnd, ma, mb;
        logic [5:0]  fn;
        longint unsigned full;
        int lat;
        bit busyDrop;

        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        sign_ext = '0; in_data1 = '0; in_data2 = '0; mem_fwd_data = '0; wb_fwd_data = '0;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; alu_op = 2'b00; alu_src = 1'b0;
        reg_dst = 1'b0; in_pc = '0; rt = '0; rd = '0;
        setCtl(5'b00000);
        clearModel();

        // Reset held for two edges
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_res", alu_result, 0);
        check("rst_zero", zero, 0);
        check("rst_data2", out_data2, 0);
        check("rst_bpc", branch_pc, 0);
        check("rst_pc", cur_pc, 0);
        check("rst_wr", wr, 0);
        check("rst_ctl", outCtl(), 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // add 5+7
        in_valid = 1'b1; alu_op = 2'b00; in_data1 = 5; in_data2 = 7;
        rd = 5'd3; rt = 5'd4; reg_dst = 1'b1; setCtl(5'b00001); in_pc = 10'd10; sign_ext = 2;
        modelEdge(); tick(); checkAll("add");
        check("add_res_lit", alu_result, 32'd12);
        check("add_zero_lit", zero, 0);
        check("add_valid_lit", out_valid, 1);

        // sub 9-9 with rs forwarded from MEM
        alu_op = 2'b01; fwd_a_sel = 2'b10; mem_fwd_data = 9; in_data1 = 100; in_data2 = 9;
        modelEdge(); tick(); checkAll("sub");
        check("sub_res_lit", alu_result, 32'd0);
        check("sub_zero_lit", zero, 1);

        // Branch target wraps modulo 2^PC_W
        alu_op = 2'b00; fwd_a_sel = 2'b00; in_pc = 10'h3FF; sign_ext = 2; setCtl(5'b10000);
        modelEdge(); tick(); checkAll("wrap");
        check("wrap_bpc_lit", branch_pc, 32'h001);

        // slt signed: -1 < 1, rt forwarded from WB
        alu_op = 2'b10; sign_ext = 32'h0000_002A; in_data1 = 32'hFFFF_FFFF;
        fwd_b_sel = 2'b01; wb_fwd_data = 1; reg_dst = 1'b0; setCtl(5'b00001);
        modelEdge(); tick(); checkAll("slt");
        check("slt_res_lit", alu_result, 32'd1);
        check("slt_data2_lit", out_data2, 32'd1);

        // nor with immediate operand B
        fwd_b_sel = 2'b00; alu_src = 1'b1; sign_ext = 32'h0000_0027; in_data1 = 32'h0F0F_0000;
        modelEdge(); tick(); checkAll("nor");
        check("nor_res_lit", alu_result, 32'hF0F0_FFD8);

        // Stall holds everything
        stall = 1'b1; alu_src = 1'b0; alu_op = 2'b00; in_data1 = 1; in_data2 = 1;
        in_pc = 10'd77; setCtl(5'b11111);
        modelEdge(); tick(); checkAll("stall");
        check("stall_res_lit", alu_result, 32'hF0F0_FFD8);
        check("stall_pc_lit", cur_pc, 32'h3FF);

        // Flush wins over stall
        flush = 1'b1;
        modelEdge(); tick(); checkAll("flstall");
        check("flstall_valid_lit", out_valid, 0);
        check("flstall_ctl_lit", outCtl(), 0);

        // Bubble
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        modelEdge(); tick(); checkAll("bubble");
        check("bubble_regwr_lit", out_reg_write, 0);

        // Unknown funct gives zero
        in_valid = 1'b1; alu_op = 2'b10; sign_ext = 32'h0000_003F; in_data1 = 32'h1234;
        modelEdge(); tick(); checkAll("unk");
        check("unk_zero_lit", zero, 1);

`ifdef EX_MUL_EN
        // mult 6*7
        alu_op = 2'b10; alu_src = 1'b0; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        sign_ext = 32'h0000_0018; in_data1 = 6; in_data2 = 7; reg_dst = 1'b1; rd = 5'd9;
        setCtl(5'b00001); in_valid = 1'b1;
        #1;
        check("mul_busy_pre", busy, 1);
        tick();
        check("mul_launch_valid", out_valid, 0);
        check("mul_launch_busy", busy, 1);
        lat = 0;
        busyDrop = 1'b0;
        for (int n = 1; n <= int'(DATA_W) + 4; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busyDrop = 1'b1;
        end
        check("mul_latency", lat, DATA_W + 1);
        check("mul_busy_held", busyDrop, 0);
        check("mul_res", alu_result, 32'd42);
        check("mul_zero", zero, 0);
        check("mul_wr", wr, 9);
        check("mul_data2", out_data2, 7);
        check("mul_ctl", outCtl(), 5'b00001);
        in_valid = 1'b0;
        #1;
        check("mul_busy_after", busy, 0);

        // Flush mid-multiply aborts
        in_valid = 1'b1; in_data1 = 3; in_data2 = 5;
        tick();
        repeat (5) tick();
        flush = 1'b1;
        tick();
        check("mulfl_valid", out_valid, 0);
        check("mulfl_ctl", outCtl(), 0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("mulfl_busy", busy, 0);

        // Stall during the multiply: steps continue, commit waits in DONE
        ma = $urandom; mb = $urandom; in_data1 = ma; in_data2 = mb; in_valid = 1'b1;
        tick();
        stall = 1'b1;
        repeat (DATA_W + 3) tick();
        check("mulst_valid_hold", out_valid, 0);
        check("mulst_busy", busy, 1);
        stall = 1'b0;
        tick();
        full = longint'(ma) * longint'(mb);
        check("mulst_valid", out_valid, 1);
        check("mulst_res", alu_result, full[31:0]);
        in_valid = 1'b0;
`else
        // Without the multiplier the mult funct decodes as unknown
        sign_ext = 32'h0000_0018; in_data1 = 6; in_data2 = 7; alu_src = 1'b0;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        #1;
        check("nomul_busy", busy, 0);
        modelEdge(); tick(); checkAll("nomul");
        check("nomul_res_lit", alu_result, 0);
        check("nomul_zero_lit", zero, 1);
        check("nomul_valid_lit", out_valid, 1);
`endif

        // Resynchronise the model with a flush edge
        flush = 1'b1;
        modelEdge(); tick(); checkAll("sync");
        flush = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            in_data1 = $urandom; in_data2 = $urandom;
            mem_fwd_data = $urandom; wb_fwd_data = $urandom;
            if ($urandom_range(0, 5) == 0) in_data2 = in_data1;
            fwd_a_sel = 2'($urandom_range(0, 3));
            fwd_b_sel = 2'($urandom_range(0, 3));
            alu_op = 2'($urandom_range(0, 3));
            alu_src = 1'($urandom_range(0, 1));
            reg_dst = 1'($urandom_range(0, 1));
            rt = 5'($urandom); rd = 5'($urandom); in_pc = 10'($urandom);
            fn = fnTable[$urandom_range(0, 7)];
`ifdef EX_MUL_EN
            if (alu_op == 2'b10 && fn == 6'h18) fn = 6'h21;
`endif
            rnd = $urandom;
            sign_ext = {rnd[31:6], fn};
            setCtl(5'($urandom));
            modelEdge(); tick(); checkAll("rnd");
            check("rnd_busy", busy, 0);
        end

        // Reset mid-run
        reset = 1'b1; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        modelEdge(); tick(); checkAll("rst2");
        check("rst2_res", alu_result, 0);
        check("rst2_pc", cur_pc, 0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
